// File: rtl/spi_write_decoder.sv
// -----------------------------------------------------------------------------
// spi_write_decoder
//
// Parses the byte stream from an SPI slave receiver as write packets and
// turns each payload byte into one memory write.
//
// Packet layout inside one SS-framed transfer:
//   WRITE_CMD, ADDR[15:8], ADDR[7:0], LEN (0 = 256), LEN payload bytes
//
// A small FIFO sits between the parser and the memory port so the memory can
// stall without losing SPI bytes. The FIFO head lives in dedicated output
// registers, so io_memAddr/io_memData/io_memValid come straight from flops.
//
// Ports:
//   clock              system clock, the only clock
//   reset              synchronous, active-high reset
//   io_byteIn          received byte from the SPI slave
//   io_byteValid       one-cycle strobe, io_byteIn holds a new byte
//   io_transferActive  high while SS is asserted
//   io_memAddr         write address of the FIFO head
//   io_memData         write data of the FIFO head
//   io_memValid        FIFO head is valid
//   io_memReady        memory accepts the head this cycle
//   io_packetDone      one-cycle pulse after the last payload byte is written
//   io_error           sticky flags: [0] bad command, [1] truncated packet,
//                      [2] overflow / extra byte
//   io_errorClear      clears io_error (a new error in the same cycle wins)
//   io_busy            parser not idle, or FIFO not empty
// -----------------------------------------------------------------------------
module spi_write_decoder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  WRITE_CMD  = 8'hA5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            io_byteIn,
  input  logic                  io_byteValid,
  input  logic                  io_transferActive,
  output logic [ADDR_WIDTH-1:0] io_memAddr,
  output logic [7:0]            io_memData,
  output logic                  io_memValid,
  input  logic                  io_memReady,
  output logic                  io_packetDone,
  output logic [2:0]            io_error,
  input  logic                  io_errorClear,
  output logic                  io_busy
);

  // The backing ring never holds more than FIFO_DEPTH-1 entries because the
  // head register accounts for the remaining slot.
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] RING_MAX = CNT_W'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_LEN     = 3'd3,
    ST_DATA    = 3'd4,
    ST_TAIL    = 3'd5,
    ST_DISCARD = 3'd6
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            data;
  } entry_t;

  // Parser state
  state_t                state_r;
  logic [7:0]            addr_hi_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [8:0]            remain_r;

  // FIFO state: head register plus ring behind it
  logic                  hd_valid_r;
  entry_t                hd_r;
  entry_t                ring_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [CNT_W-1:0]      rcnt_r;

  // Status
  logic                  packet_done_r;
  logic [2:0]            error_r;

  // Combinational control
  logic                  accept_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  push_s;
  logic                  drop_s;
  logic                  hd_load_s;
  logic                  ring_re_s;
  logic                  ring_we_s;
  logic                  ring_empty_s;
  entry_t                push_entry_s;
  logic [2:0]            err_set_s;

  assign accept_s     = io_byteValid & io_transferActive;
  assign pop_s        = hd_valid_r & io_memReady;
  assign ring_empty_s = (rcnt_r == {CNT_W{1'b0}});
  assign full_s       = hd_valid_r & (rcnt_r == RING_MAX);
  // Head reloads whenever it is empty or being consumed this cycle.
  assign hd_load_s    = ~hd_valid_r | pop_s;

  // Payload push / drop decision; a pop in the same cycle frees a slot.
  always_comb begin
    push_s = 1'b0;
    drop_s = 1'b0;
    if (accept_s && (state_r == ST_DATA)) begin
      if (!full_s || pop_s) begin
        push_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  // Entry built from the current address and incoming byte.
  always_comb begin
    push_entry_s      = '0;
    push_entry_s.last = (remain_r == 9'd1);
    push_entry_s.addr = addr_r;
    push_entry_s.data = io_byteIn;
  end

  // Ring read/write strobes; a push into an empty FIFO bypasses the ring.
  always_comb begin
    ring_re_s = 1'b0;
    ring_we_s = 1'b0;
    if (hd_load_s && !ring_empty_s) begin
      ring_re_s = 1'b1;
      ring_we_s = push_s;
    end else if (hd_load_s) begin
      ring_re_s = 1'b0;
      ring_we_s = 1'b0;
    end else begin
      ring_re_s = 1'b0;
      ring_we_s = push_s;
    end
  end

  // Error events raised this cycle.
  always_comb begin
    err_set_s = 3'b000;
    if (accept_s && (state_r == ST_IDLE) && (io_byteIn != WRITE_CMD)) begin
      err_set_s[0] = 1'b1;
    end else begin
      err_set_s[0] = 1'b0;
    end
    if (!io_transferActive &&
        ((state_r == ST_ADDR_HI) || (state_r == ST_ADDR_LO) ||
         (state_r == ST_LEN)     || (state_r == ST_DATA))) begin
      err_set_s[1] = 1'b1;
    end else begin
      err_set_s[1] = 1'b0;
    end
    if (drop_s || (accept_s && (state_r == ST_TAIL))) begin
      err_set_s[2] = 1'b1;
    end else begin
      err_set_s[2] = 1'b0;
    end
  end

  // Packet parser FSM: header capture, address/length tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      addr_hi_r <= 8'd0;
      addr_r    <= '0;
      remain_r  <= 9'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (io_byteIn == WRITE_CMD) begin
              state_r <= ST_ADDR_HI;
            end else begin
              state_r <= ST_DISCARD;
            end
          end
        end
        ST_ADDR_HI: begin
          if (!io_transferActive) begin
            state_r <= ST_IDLE;
          end else if (accept_s) begin
            addr_hi_r <= io_byteIn;
            state_r   <= ST_ADDR_LO;
          end
        end
        ST_ADDR_LO: begin
          if (!io_transferActive) begin
            state_r <= ST_IDLE;
          end else if (accept_s) begin
            // The header always carries 16 bits; the cast zero-extends or
            // truncates to the configured address width.
            addr_r  <= ADDR_WIDTH'({addr_hi_r, io_byteIn});
            state_r <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (!io_transferActive) begin
            state_r <= ST_IDLE;
          end else if (accept_s) begin
            remain_r <= (io_byteIn == 8'd0) ? 9'd256 : {1'b0, io_byteIn};
            state_r  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!io_transferActive) begin
            state_r <= ST_IDLE;
          end else if (accept_s) begin
            // Address and count advance even for a dropped byte, so later
            // bytes still land on their intended addresses.
            addr_r   <= addr_r + ADDR_WIDTH'(1);
            remain_r <= remain_r - 9'd1;
            if (remain_r == 9'd1) begin
              state_r <= ST_TAIL;
            end
          end
        end
        ST_TAIL, ST_DISCARD: begin
          if (!io_transferActive) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Payload FIFO: ring storage, pointers and the registered head entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        ring_r[i] <= '0;
      end
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      rcnt_r     <= '0;
      hd_valid_r <= 1'b0;
      hd_r       <= '0;
    end else begin
      if (ring_we_s) begin
        ring_r[wr_ptr_r] <= push_entry_s;
        wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
      end
      if (ring_re_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({ring_we_s, ring_re_s})
        2'b10:   rcnt_r <= rcnt_r + CNT_W'(1);
        2'b01:   rcnt_r <= rcnt_r - CNT_W'(1);
        default: rcnt_r <= rcnt_r;
      endcase
      if (hd_load_s) begin
        if (ring_re_s) begin
          hd_r       <= ring_r[rd_ptr_r];
          hd_valid_r <= 1'b1;
        end else if (push_s) begin
          hd_r       <= push_entry_s;
          hd_valid_r <= 1'b1;
        end else begin
          // Address/data keep their last value; only valid drops.
          hd_valid_r <= 1'b0;
        end
      end
    end
  end

  // Completion pulse one cycle after the last-tagged entry is written.
  always_ff @(posedge clock) begin
    if (reset) begin
      packet_done_r <= 1'b0;
    end else begin
      packet_done_r <= pop_s & hd_r.last;
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      error_r <= 3'b000;
    end else if (io_errorClear) begin
      error_r <= err_set_s;
    end else begin
      error_r <= error_r | err_set_s;
    end
  end

  assign io_memValid   = hd_valid_r;
  assign io_memAddr    = hd_r.addr;
  assign io_memData    = hd_r.data;
  assign io_packetDone = packet_done_r;
  assign io_error      = error_r;
  assign io_busy       = (state_r != ST_IDLE) | hd_valid_r;

endmodule

// File: tb/tb_spi_write_decoder.sv
module tb_spi_write_decoder;

  logic        clock;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        xfer;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_valid;
  logic        mem_ready;
  logic        pkt_done;
  logic [2:0]  error;
  logic        err_clr;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  spi_write_decoder dut (
    .clock             (clock),
    .reset             (reset),
    .io_byteIn         (byte_in),
    .io_byteValid      (byte_valid),
    .io_transferActive (xfer),
    .io_memAddr        (mem_addr),
    .io_memData        (mem_data),
    .io_memValid       (mem_valid),
    .io_memReady       (mem_ready),
    .io_packetDone     (pkt_done),
    .io_error          (error),
    .io_errorClear     (err_clr),
    .io_busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Write log and packetDone count, sampled mid-cycle away from the edge.
  logic [23:0] wq [$];
  int pd_count = 0;
  always @(negedge clock) begin
    if (mem_valid === 1'b1 && mem_ready === 1'b1) wq.push_back({mem_addr, mem_data});
    if (pkt_done === 1'b1) pd_count <= pd_count + 1;
  end

  typedef struct {
    logic        rst, ta, bv;
    logic [7:0]  b;
    logic        rdy, clr;
    logic        mv;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        pd;
    logic [2:0]  err;
    logic        bz;
  } vec_t;
  vec_t vecs [$];

  task automatic add(input logic r, t, v, input logic [7:0] b, input logic rd, c,
                     input logic m, input logic [15:0] a, input logic [7:0] d,
                     input logic p, input logic [2:0] e, input logic bz);
    vec_t x;
    x.rst = r; x.ta = t; x.bv = v; x.b = b; x.rdy = rd; x.clr = c;
    x.mv = m; x.addr = a; x.data = d; x.pd = p; x.err = e; x.bz = bz;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] get_wr(input int idx);
    if (idx < wq.size()) return wq[idx];
    else return 24'hxxxxxx;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    xfer = 1'b1; byte_valid = 1'b1; byte_in = b;
    cyc();
    byte_valid = 1'b0;
  endtask

  task automatic end_xfer();
    xfer = 1'b0; byte_valid = 1'b0;
    cyc();
  endtask

  int base;
  int pdb;
  int bad;
  logic [23:0] w;

  initial begin
    reset = 1'b0; byte_in = 8'd0; byte_valid = 1'b0; xfer = 1'b0;
    mem_ready = 1'b0; err_clr = 1'b0;

    //  rst ta bv byte   rdy clr | mv addr      data   pd err     busy
    add(1, 0, 0, 8'h00, 0, 0,    0, 16'h0000, 8'h00, 0, 3'b000, 0); // reset
    add(0, 1, 1, 8'hA5, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b000, 1); // basic write
    add(0, 1, 1, 8'h12, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b000, 1);
    add(0, 1, 1, 8'h34, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b000, 1);
    add(0, 1, 1, 8'h03, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b000, 1);
    add(0, 1, 1, 8'hAA, 1, 0,    1, 16'h1234, 8'hAA, 0, 3'b000, 1);
    add(0, 1, 1, 8'hBB, 1, 0,    1, 16'h1235, 8'hBB, 0, 3'b000, 1);
    add(0, 1, 1, 8'hCC, 1, 0,    1, 16'h1236, 8'hCC, 0, 3'b000, 1);
    add(0, 1, 0, 8'h00, 1, 0,    0, 16'h0000, 8'h00, 1, 3'b000, 1);
    add(0, 0, 0, 8'h00, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b000, 0);
    add(0, 0, 1, 8'h5A, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b000, 0); // SS low: ignored
    add(0, 1, 1, 8'h5A, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b001, 1); // bad command
    add(0, 1, 1, 8'hA5, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b001, 1); // discarded
    add(0, 0, 0, 8'h00, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b001, 0);
    add(0, 0, 0, 8'h00, 1, 1,    0, 16'h0000, 8'h00, 0, 3'b000, 0); // clear
    add(0, 1, 1, 8'hA5, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b000, 1); // truncation
    add(0, 1, 1, 8'h10, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b000, 1);
    add(0, 0, 0, 8'h00, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b010, 0);
    add(0, 1, 1, 8'h5A, 1, 1,    0, 16'h0000, 8'h00, 0, 3'b001, 1); // set beats clear
    add(0, 0, 0, 8'h00, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b001, 0);
    add(0, 1, 1, 8'hA5, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b001, 1);
    add(0, 0, 0, 8'h00, 1, 1,    0, 16'h0000, 8'h00, 0, 3'b010, 0); // truncate + clear
    add(0, 0, 0, 8'h00, 1, 1,    0, 16'h0000, 8'h00, 0, 3'b000, 0);
    add(0, 1, 1, 8'hA5, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b000, 1); // len 1 + extra
    add(0, 1, 1, 8'h00, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b000, 1);
    add(0, 1, 1, 8'h07, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b000, 1);
    add(0, 1, 1, 8'h01, 1, 0,    0, 16'h0000, 8'h00, 0, 3'b000, 1);
    add(0, 1, 1, 8'h5C, 1, 0,    1, 16'h0007, 8'h5C, 0, 3'b000, 1);
    add(0, 1, 1, 8'h99, 1, 0,    0, 16'h0000, 8'h00, 1, 3'b100, 1);
    add(0, 0, 0, 8'h00, 1, 1,    0, 16'h0000, 8'h00, 0, 3'b000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      logic chk;
      reset = vecs[i].rst; xfer = vecs[i].ta; byte_valid = vecs[i].bv;
      byte_in = vecs[i].b; mem_ready = vecs[i].rdy; err_clr = vecs[i].clr;
      cyc();
      chk = vecs[i].mv | vecs[i].rst;
      check($sformatf("vec%0d", i),
            {mem_valid, pkt_done, error, busy,
             chk ? mem_addr : 16'h0000, chk ? mem_data : 8'h00},
            {vecs[i].mv, vecs[i].pd, vecs[i].err, vecs[i].bz,
             chk ? vecs[i].addr : 16'h0000, chk ? vecs[i].data : 8'h00});
    end
    reset = 1'b0; err_clr = 1'b0; byte_valid = 1'b0; xfer = 1'b0;
    cyc();

    // Back-pressure: head held stable for 20 cycles, then in-order drain.
    base = wq.size(); pdb = pd_count; mem_ready = 1'b0;
    send(8'hA5); send(8'h12); send(8'h34); send(8'h03);
    send(8'hAA); send(8'hBB); send(8'hCC); end_xfer();
    for (int i = 0; i < 20; i++) begin
      check("bp_hold", {mem_valid, busy, mem_addr, mem_data}, {1'b1, 1'b1, 16'h1234, 8'hAA});
      cyc();
    end
    check("bp_err", error, 3'b000);
    mem_ready = 1'b1; repeat (8) cyc();
    check("bp_count", wq.size() - base, 3);
    check("bp_wr0", get_wr(base),     {16'h1234, 8'hAA});
    check("bp_wr1", get_wr(base + 1), {16'h1235, 8'hBB});
    check("bp_wr2", get_wr(base + 2), {16'h1236, 8'hCC});
    check("bp_done", pd_count - pdb, 1);

    // Overflow: 6 bytes into a 4-deep FIFO with memory stalled.
    base = wq.size(); pdb = pd_count; mem_ready = 1'b0;
    send(8'hA5); send(8'h00); send(8'h00); send(8'h06);
    for (int i = 0; i < 6; i++) send(8'(8'h10 + i));
    end_xfer();
    check("ovf_err", error, 3'b100);
    mem_ready = 1'b1; repeat (8) cyc();
    check("ovf_count", wq.size() - base, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("ovf_wr%0d", i), get_wr(base + i), {16'(i), 8'(8'h10 + i)});
    check("ovf_no_done", pd_count - pdb, 0);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    check("ovf_clear", error, 3'b000);

    // Address wrap with length 0 (256 bytes), then one extra byte.
    base = wq.size(); pdb = pd_count; mem_ready = 1'b1;
    send(8'hA5); send(8'hFF); send(8'hFF); send(8'h00);
    for (int i = 0; i < 256; i++) send(8'(i));
    check("wrap_err_before_extra", {error, busy}, {3'b000, 1'b1});
    send(8'h77);
    check("wrap_err_extra", error, 3'b100);
    end_xfer(); repeat (4) cyc();
    check("wrap_count", wq.size() - base, 256);
    check("wrap_first", get_wr(base),       {16'hFFFF, 8'h00});
    check("wrap_second", get_wr(base + 1),  {16'h0000, 8'h01});
    check("wrap_last", get_wr(base + 255),  {16'h00FE, 8'hFF});
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      w = get_wr(base + i);
      if (w !== {16'(16'hFFFF + i), 8'(i)}) bad++;
    end
    check("wrap_seq_bad_entries", bad, 0);
    check("wrap_done", pd_count - pdb, 1);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;

    // Full FIFO with simultaneous push and pop: nothing dropped.
    base = wq.size(); pdb = pd_count; mem_ready = 1'b0;
    send(8'hA5); send(8'h40); send(8'h00); send(8'h05);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    check("full_head", {mem_valid, mem_addr, mem_data}, {1'b1, 16'h4000, 8'h01});
    mem_ready = 1'b1; send(8'h05); end_xfer(); repeat (8) cyc();
    check("full_err", error, 3'b000);
    check("full_count", wq.size() - base, 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("full_wr%0d", i), get_wr(base + i), {16'(16'h4000 + i), 8'(i + 1)});
    check("full_done", pd_count - pdb, 1);

    // Next packet accepted while the previous payload is still queued.
    base = wq.size(); pdb = pd_count; mem_ready = 1'b0;
    send(8'hA5); send(8'h50); send(8'h00); send(8'h01); send(8'hE1); end_xfer();
    send(8'hA5); send(8'h60); send(8'h00); send(8'h01); send(8'hE2); end_xfer();
    check("b2b_err", error, 3'b000);
    mem_ready = 1'b1; repeat (6) cyc();
    check("b2b_count", wq.size() - base, 2);
    check("b2b_wr0", get_wr(base),     {16'h5000, 8'hE1});
    check("b2b_wr1", get_wr(base + 1), {16'h6000, 8'hE2});
    check("b2b_done", pd_count - pdb, 2);

    // Reset in the middle of DATA discards everything queued.
    mem_ready = 1'b0;
    send(8'h5A); end_xfer();  // leave an error flag set before the reset
    base = wq.size(); pdb = pd_count;
    send(8'hA5); send(8'h20); send(8'h00); send(8'h04); send(8'hAA); send(8'hBB);
    reset = 1'b1; xfer = 1'b0; cyc(); reset = 1'b0;
    check("rst_state", {mem_valid, busy, error, pkt_done}, {1'b0, 1'b0, 3'b000, 1'b0});
    mem_ready = 1'b1; cyc();
    send(8'hA5); send(8'h30); send(8'h00); send(8'h02); send(8'h11); send(8'h22);
    end_xfer(); repeat (5) cyc();
    check("rst_count", wq.size() - base, 2);
    check("rst_wr0", get_wr(base),     {16'h3000, 8'h11});
    check("rst_wr1", get_wr(base + 1), {16'h3001, 8'h22});
    check("rst_done", pd_count - pdb, 1);
    check("rst_err", error, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
